// File: rtl/anc_tap_sequencer.sv
// Per-sample control sequencer for the time-multiplexed ANC FIR/LMS datapath.
// Orders shift, serial MAC and coefficient-update phases; no arithmetic here.
module anc_tap_sequencer #(
  parameter int TAPS        = 4,
  parameter int AW          = 2,
  parameter int ERR_TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sample_valid,
  input  logic          adapt_en,
  input  logic          err_valid,
  input  logic          clr_flags,
  output logic          sample_ready,
  output logic          shift_en,
  output logic          mac_clr,
  output logic          mac_en,
  output logic [AW-1:0] tap_idx,
  output logic          coef_rd_en,
  output logic          coef_wr_en,
  output logic [AW-1:0] wr_idx,
  output logic          y_valid,
  output logic          busy,
  output logic          overrun,
  output logic          err_timeout
);

  localparam int CW = AW + 1;
  localparam int TW = (ERR_TIMEOUT > 1) ? $clog2(ERR_TIMEOUT) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SHIFT    = 3'd1;
  localparam logic [2:0] S_FILT     = 3'd2;
  localparam logic [2:0] S_FDONE    = 3'd3;
  localparam logic [2:0] S_WAIT_ERR = 3'd4;
  localparam logic [2:0] S_UPD      = 3'd5;

  localparam logic [CW-1:0] CNT_LAST_TAP = CW'(TAPS - 1);
  localparam logic [CW-1:0] CNT_LAST_UPD = CW'(TAPS);
  localparam logic [TW-1:0] TMR_LAST     = TW'(ERR_TIMEOUT - 1);

  logic [2:0]    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [TW-1:0] tmr, tmr_nx;
  logic          tmo_set;
  logic          ovr_set;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    tmr_nx   = tmr;
    tmo_set  = 1'b0;
    case (state)
      S_IDLE: begin
        if (sample_valid) state_nx = S_SHIFT;
      end
      S_SHIFT: begin
        state_nx = S_FILT;
        cnt_nx   = '0;
      end
      S_FILT: begin
        if (cnt == CNT_LAST_TAP) begin
          state_nx = S_FDONE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_FDONE: begin
        if (adapt_en) begin
          state_nx = S_WAIT_ERR;
          tmr_nx   = '0;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_WAIT_ERR: begin
        // err_valid on the final timer cycle still wins over the timeout
        if (err_valid) begin
          state_nx = S_UPD;
          cnt_nx   = '0;
        end else if (tmr == TMR_LAST) begin
          state_nx = S_IDLE;
          tmr_nx   = '0;
          tmo_set  = 1'b1;
        end else begin
          tmr_nx = tmr + 1'b1;
        end
      end
      S_UPD: begin
        if (cnt == CNT_LAST_UPD) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
        tmr_nx   = '0;
      end
    endcase
  end

  assign ovr_set = sample_valid && (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      tmr         <= '0;
      overrun     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      tmr   <= tmr_nx;
      if (ovr_set)        overrun <= 1'b1;
      else if (clr_flags) overrun <= 1'b0;
      if (tmo_set)        err_timeout <= 1'b1;
      else if (clr_flags) err_timeout <= 1'b0;
    end
  end

  // UPD is a one-deep read-modify-write: reads lead writes by one cycle
  always_comb begin
    sample_ready = (state == S_IDLE);
    busy         = (state != S_IDLE);
    shift_en     = (state == S_SHIFT);
    mac_en       = (state == S_FILT);
    mac_clr      = (state == S_FILT) && (cnt == '0);
    y_valid      = (state == S_FDONE);
    coef_rd_en   = (state == S_UPD) && (cnt != CNT_LAST_UPD);
    coef_wr_en   = (state == S_UPD) && (cnt != '0);
    tap_idx      = '0;
    wr_idx       = '0;
    if ((state == S_FILT) || ((state == S_UPD) && (cnt != CNT_LAST_UPD)))
      tap_idx = cnt[AW-1:0];
    if ((state == S_UPD) && (cnt != '0))
      wr_idx = AW'(cnt - 1'b1);
  end

endmodule

// File: tb/tb_anc_tap_sequencer.sv
// Scoreboard bench for anc_tap_sequencer: a cycle-timeline reference model
// predicts strobe events; a negedge monitor pops and compares them.
module tb_anc_tap_sequencer;

  localparam int TAPS        = 4;
  localparam int AW          = 2;
  localparam int ERR_TIMEOUT = 16;
  localparam int VW          = 6 + 2 * AW;
  localparam int FAR         = 32'h7fff_ffff;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          sample_valid = 1'b0;
  logic          adapt_en = 1'b0;
  logic          err_valid = 1'b0;
  logic          clr_flags = 1'b0;
  logic          sample_ready, shift_en, mac_clr, mac_en;
  logic [AW-1:0] tap_idx, wr_idx;
  logic          coef_rd_en, coef_wr_en, y_valid, busy, overrun, err_timeout;

  anc_tap_sequencer #(.TAPS(TAPS), .AW(AW), .ERR_TIMEOUT(ERR_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .adapt_en(adapt_en),
    .err_valid(err_valid), .clr_flags(clr_flags), .sample_ready(sample_ready),
    .shift_en(shift_en), .mac_clr(mac_clr), .mac_en(mac_en), .tap_idx(tap_idx),
    .coef_rd_en(coef_rd_en), .coef_wr_en(coef_wr_en), .wr_idx(wr_idx),
    .y_valid(y_valid), .busy(busy), .overrun(overrun), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int             at;
    logic [VW-1:0]  vec;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference timeline: when the model is free, and what phase is pending
  int   free_at, fdone_at, win_lo, win_hi;
  bit   waiting;
  logic m_ovr, m_tmo;
  logic ready_exp = 1'b1, ovr_exp = 1'b0, tmo_exp = 1'b0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic logic [VW-1:0] mk(logic sh, logic cl, logic mc, logic [AW-1:0] t,
                                       logic rd, logic wr, logic [AW-1:0] w, logic y);
    return {sh, cl, mc, t, rd, wr, w, y};
  endfunction

  function automatic void push(int at, logic [VW-1:0] v);
    exp_t e;
    e.at  = at;
    e.vec = v;
    q.push_back(e);
  endfunction

  function automatic void model_clear();
    q.delete();
    free_at   = 0;
    fdone_at  = -1;
    win_lo    = 0;
    win_hi    = 0;
    waiting   = 1'b0;
    m_ovr     = 1'b0;
    m_tmo     = 1'b0;
    ready_exp = 1'b1;
    ovr_exp   = 1'b0;
    tmo_exp   = 1'b0;
  endfunction

  // Drive one cycle of inputs, advance the reference timeline, wait one clock
  task automatic step(input logic sv, input logic ae, input logic ev, input logic cf);
    int   c;
    logic so, st;
    c  = cyc;
    so = 1'b0;
    st = 1'b0;
    sample_valid = sv;
    adapt_en     = ae;
    err_valid    = ev;
    clr_flags    = cf;
    ready_exp = (c >= free_at);
    ovr_exp   = m_ovr;
    tmo_exp   = m_tmo;
    if (sv) begin
      if (c >= free_at) begin
        push(c + 1, mk(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0));
        for (int k = 0; k < TAPS; k++)
          push(c + 2 + k, mk(1'b0, k == 0, 1'b1, AW'(k), 1'b0, 1'b0, '0, 1'b0));
        push(c + TAPS + 2, mk(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1));
        fdone_at = c + TAPS + 2;
        free_at  = FAR;
      end else begin
        so = 1'b1;
      end
    end
    if (c == fdone_at) begin
      fdone_at = -1;
      if (ae) begin
        waiting = 1'b1;
        win_lo  = c + 1;
        win_hi  = c + ERR_TIMEOUT;
      end else begin
        free_at = c + 1;
      end
    end else if (waiting && c >= win_lo) begin
      if (ev) begin
        for (int k = 0; k <= TAPS; k++)
          push(c + 1 + k, mk(1'b0, 1'b0, 1'b0, (k < TAPS) ? AW'(k) : '0,
                             k < TAPS, k >= 1, (k >= 1) ? AW'(k - 1) : '0, 1'b0));
        free_at = c + TAPS + 2;
        waiting = 1'b0;
      end else if (c == win_hi) begin
        st      = 1'b1;
        free_at = c + 1;
        waiting = 1'b0;
      end
    end
    m_ovr = so ? 1'b1 : (cf ? 1'b0 : m_ovr);
    m_tmo = st ? 1'b1 : (cf ? 1'b0 : m_tmo);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic ae);
    for (int i = 0; i < n; i++) step(1'b0, ae, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_sample_ready", sample_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_shift_en", shift_en, 0);
    chk("rst_mac_clr", mac_clr, 0);
    chk("rst_mac_en", mac_en, 0);
    chk("rst_tap_idx", tap_idx, 0);
    chk("rst_coef_rd_en", coef_rd_en, 0);
    chk("rst_coef_wr_en", coef_wr_en, 0);
    chk("rst_wr_idx", wr_idx, 0);
    chk("rst_y_valid", y_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_err_timeout", err_timeout, 0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before the next edge
  task automatic reset_pulse();
    rst_n        = 1'b0;
    sample_valid = 1'b0;
    adapt_en     = 1'b0;
    err_valid    = 1'b0;
    clr_flags    = 1'b0;
    model_clear();
    #1;
    chk_reset_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: flag/ready checks every cycle, strobe vector against the scoreboard
  always @(negedge clk) begin
    logic [VW-1:0] act;
    exp_t          e;
    chk("sample_ready", sample_ready, ready_exp);
    chk("busy", busy, !ready_exp);
    chk("overrun", overrun, ovr_exp);
    chk("err_timeout", err_timeout, tmo_exp);
    while (q.size() > 0 && q[0].at < cyc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL missed_event: got nothing, want %0h (due cycle %0d, now %0d)",
               q[0].vec, q[0].at, cyc);
      void'(q.pop_front());
    end
    act = {shift_en, mac_clr, mac_en, tap_idx, coef_rd_en, coef_wr_en, wr_idx, y_valid};
    if (act != '0) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_event: got %0h, want none (cycle %0d)", act, cyc);
      end else if (q[0].at != cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL early_event: got %0h at cycle %0d, want it at cycle %0d",
                 act, cyc, q[0].at);
      end else begin
        e = q.pop_front();
        chk("outputs", act, e.vec);
      end
    end
  end

  initial begin
    model_clear();
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Plain filter pass, no adaptation
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(12, 1'b0);

    // Adaptation with err_valid in cycle 9 relative to the sample
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k < 20; k++) step(1'b0, 1'b1, k == 9, 1'b0);

    // Error never arrives: timeout, then a late err_valid is ignored
    step(1'b1, 1'b1, 1'b0, 1'b0);
    idle(30, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    idle(8, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);

    // Overruns at cycle 3 and in the last UPD cycle; accept one cycle later;
    // clr_flags coincident with another overrun must leave overrun set
    for (int k = 0; k < 36; k++)
      step(k == 0 || k == 3 || k == 14 || k == 15 || k == 17, 1'b1,
           k == 9 || k == 25, k == 17);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);

    // Reset in the middle of FILT, then a normal sample
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    reset_pulse();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(10, 1'b0);

    // Back-to-back at the minimum sample period
    for (int n = 0; n < 70; n++) step((n % 7) == 0, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 800; n++)
      step($urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 24) == 0, $urandom_range(0, 19) == 0);

    idle(40, 1'b0);
    chk("queue_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
